// File: rtl/ariane_pkg.sv
// Shared types for the issue/commit scoreboard: functional units, exceptions and entry records.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 8;
    localparam int unsigned NR_WB_PORTS   = 2;
    localparam int unsigned TRANS_ID_BITS = 5;

    typedef enum logic [2:0] {
        NONE,
        LSU,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/sb_lookup.sv
// Youngest-writer search: walks busy entries from the head (oldest) towards the tail so the
// last match seen is the youngest in-flight writer of addr_i.
module sb_lookup
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic [NR_ENTRIES-1:0]         busy_i,
    input  logic [NR_ENTRIES-1:0]         valid_i,
    input  logic [$clog2(NR_ENTRIES)-1:0] rptr_i,
    input  logic [4:0]                    rd_i     [NR_ENTRIES],
    input  fu_t                           fu_i     [NR_ENTRIES],
    input  logic [63:0]                   result_i [NR_ENTRIES],
    input  logic [4:0]                    addr_i,
    output logic                          hit_o,
    output fu_t                           fu_o,
    output logic                          valid_o,
    output logic [63:0]                   result_o
);

    localparam int unsigned PtrW = $clog2(NR_ENTRIES);

    logic [PtrW-1:0] idx;

    // Later (younger) matches override earlier ones; x0 is never a real destination.
    always_comb begin
        hit_o    = 1'b0;
        fu_o     = NONE;
        valid_o  = 1'b0;
        result_o = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            idx = rptr_i + PtrW'(i);
            if (busy_i[idx] && (rd_i[idx] == addr_i) && (addr_i != 5'd0)) begin
                hit_o    = 1'b1;
                fu_o     = fu_i[idx];
                valid_o  = valid_i[idx];
                result_o = result_i[idx];
            end
        end
    end

endmodule

// File: rtl/scoreboard.sv
// In-order circular scoreboard: issue at wptr, out-of-order writeback by trans_id,
// in-order commit from rptr, plus rd-clobber and operand-forwarding lookups.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  scoreboard_entry_t                         issue_instr_i,
    input  logic                                      issue_valid_i,
    output logic                                      issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]              wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i,
    output scoreboard_entry_t                         commit_instr_o,
    output logic                                      commit_valid_o,
    input  logic                                      commit_ack_i,
    output fu_t [31:0]                                rd_clobber_o,
    input  logic [4:0]                                rs1_i,
    input  logic [4:0]                                rs2_i,
    output logic                                      rs1_fwd_o,
    output logic                                      rs2_fwd_o,
    output logic [63:0]                               rs1_data_o,
    output logic [63:0]                               rs2_data_o
);

    localparam int unsigned PtrW = $clog2(NR_ENTRIES);
    localparam int unsigned CntW = PtrW + 1;

    scoreboard_entry_t     mem_q [NR_ENTRIES];
    scoreboard_entry_t     issue_entry;
    logic [NR_ENTRIES-1:0] busy_q, busy_d, valid_q, valid_d;
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [CntW-1:0]       count_q;
    logic                  issue_fire, commit_fire;
    logic [PtrW-1:0]       wb_idx [NR_WB_PORTS];
    logic                  wb_conflict;

    logic [4:0]  rd_arr  [NR_ENTRIES];
    fu_t         fu_arr  [NR_ENTRIES];
    logic [63:0] res_arr [NR_ENTRIES];

    assign issue_ready_o    = (count_q != CntW'(NR_ENTRIES));
    assign issue_fire       = issue_valid_i & issue_ready_o;
    assign issue_trans_id_o = TRANS_ID_BITS'(wptr_q);
    assign commit_valid_o   = busy_q[rptr_q] & valid_q[rptr_q];
    assign commit_fire      = commit_valid_o & commit_ack_i;

    // Head entry presented with its live finished bit.
    always_comb begin
        commit_instr_o       = mem_q[rptr_q];
        commit_instr_o.valid = valid_q[rptr_q];
        issue_entry          = issue_instr_i;
        issue_entry.trans_id = TRANS_ID_BITS'(wptr_q);
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            wb_idx[p] = PtrW'(wb_trans_id_i[p]);
        end
    end

    // Busy/finished next state; a freshly issued slot is never busy, so writeback cannot hit it.
    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && busy_q[wb_idx[p]]) begin
                valid_d[wb_idx[p]] = 1'b1;
            end
        end
        if (issue_fire) begin
            busy_d[wptr_q]  = 1'b1;
            valid_d[wptr_q] = issue_instr_i.ex.valid;
        end
        if (commit_fire) begin
            busy_d[rptr_q] = 1'b0;
        end
    end

    // Control state: pointers, occupancy and per-slot status; flush behaves like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PtrW'(issue_fire);
            rptr_q  <= rptr_q + PtrW'(commit_fire);
            count_q <= count_q + CntW'(issue_fire) - CntW'(commit_fire);
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Entry payloads carry no reset; the busy bits say which ones mean anything.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && busy_q[wb_idx[p]]) begin
                    mem_q[wb_idx[p]].result <= wb_result_i[p];
                    if (wb_ex_i[p].valid) begin
                        mem_q[wb_idx[p]].ex <= wb_ex_i[p];
                    end
                end
            end
            if (issue_fire) begin
                mem_q[wptr_q] <= issue_entry;
            end
        end
    end

    // Flatten the fields the lookups need.
    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            rd_arr[i]  = mem_q[i].rd;
            fu_arr[i]  = mem_q[i].fu;
            res_arr[i] = mem_q[i].result;
        end
    end

    logic        rs1_hit, rs2_hit, rs1_valid, rs2_valid;
    fu_t         rs1_fu, rs2_fu;
    logic [63:0] rs1_res, rs2_res;

    sb_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs1_lookup (
        .busy_i   (busy_q),
        .valid_i  (valid_q),
        .rptr_i   (rptr_q),
        .rd_i     (rd_arr),
        .fu_i     (fu_arr),
        .result_i (res_arr),
        .addr_i   (rs1_i),
        .hit_o    (rs1_hit),
        .fu_o     (rs1_fu),
        .valid_o  (rs1_valid),
        .result_o (rs1_res)
    );

    sb_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs2_lookup (
        .busy_i   (busy_q),
        .valid_i  (valid_q),
        .rptr_i   (rptr_q),
        .rd_i     (rd_arr),
        .fu_i     (fu_arr),
        .result_i (res_arr),
        .addr_i   (rs2_i),
        .hit_o    (rs2_hit),
        .fu_o     (rs2_fu),
        .valid_o  (rs2_valid),
        .result_o (rs2_res)
    );

    // Forward only when the youngest writer itself has finished.
    assign rs1_fwd_o  = rs1_hit & rs1_valid;
    assign rs2_fwd_o  = rs2_hit & rs2_valid;
    assign rs1_data_o = rs1_fwd_o ? rs1_res : 64'd0;
    assign rs2_data_o = rs2_fwd_o ? rs2_res : 64'd0;

    logic        clob_hit   [32];
    fu_t         clob_fu    [32];
    logic        clob_valid [32];
    logic [63:0] clob_res   [32];

    assign clob_hit[0]   = 1'b0;
    assign clob_fu[0]    = NONE;
    assign clob_valid[0] = 1'b0;
    assign clob_res[0]   = '0;

    for (genvar r = 1; r < 32; r++) begin : g_clobber
        sb_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_clob_lookup (
            .busy_i   (busy_q),
            .valid_i  (valid_q),
            .rptr_i   (rptr_q),
            .rd_i     (rd_arr),
            .fu_i     (fu_arr),
            .result_i (res_arr),
            .addr_i   (5'(r)),
            .hit_o    (clob_hit[r]),
            .fu_o     (clob_fu[r]),
            .valid_o  (clob_valid[r]),
            .result_o (clob_res[r])
        );
    end

    // Pack clobber FUs; x0 stays NONE.
    always_comb begin
        rd_clobber_o = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            rd_clobber_o[r] = clob_hit[r] ? clob_fu[r] : NONE;
        end
    end

    // Detect two writeback ports targeting the same entry in one cycle.
    always_comb begin
        wb_conflict = 1'b0;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            for (int unsigned q = p + 1; q < NR_WB_PORTS; q++) begin
                if (wb_valid_i[p] && wb_valid_i[q] && (wb_trans_id_i[p] == wb_trans_id_i[q])) begin
                    wb_conflict = 1'b1;
                end
            end
        end
    end

    a_wb_unique: assert property (@(posedge clk_i) disable iff (rst_i) !wb_conflict);
    a_ack_valid: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                  commit_ack_i |-> commit_valid_o);

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: fill/wrap, out-of-order writeback, forwarding, flush.
module tb_scoreboard;
    import ariane_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           flush = 1'b0;
    scoreboard_entry_t              issue_instr = '0;
    logic                           issue_valid = 1'b0;
    logic                           issue_ready;
    logic [TRANS_ID_BITS-1:0]       issue_tid;
    logic [1:0]                     wb_valid = '0;
    logic [1:0][TRANS_ID_BITS-1:0]  wb_tid = '0;
    logic [1:0][63:0]               wb_res = '0;
    exception_t [1:0]               wb_ex = '0;
    scoreboard_entry_t              commit_instr;
    logic                           commit_valid;
    logic                           commit_ack = 1'b0;
    fu_t [31:0]                     rd_clobber;
    logic [4:0]                     rs1 = '0, rs2 = '0;
    logic                           rs1_fwd, rs2_fwd;
    logic [63:0]                    rs1_data, rs2_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard #(.NR_ENTRIES(8), .NR_WB_PORTS(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .issue_instr_i    (issue_instr),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_trans_id_o (issue_tid),
        .wb_valid_i       (wb_valid),
        .wb_trans_id_i    (wb_tid),
        .wb_result_i      (wb_res),
        .wb_ex_i          (wb_ex),
        .commit_instr_o   (commit_instr),
        .commit_valid_o   (commit_valid),
        .commit_ack_i     (commit_ack),
        .rd_clobber_o     (rd_clobber),
        .rs1_i            (rs1),
        .rs2_i            (rs2),
        .rs1_fwd_o        (rs1_fwd),
        .rs2_fwd_o        (rs2_fwd),
        .rs1_data_o       (rs1_data),
        .rs2_data_o       (rs2_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input fu_t fu, input logic exv);
        issue_instr          = '0;
        issue_instr.rd       = rd;
        issue_instr.fu       = fu;
        issue_instr.ex.valid = exv;
        issue_instr.trans_id = 5'h1f;
        issue_valid          = 1'b1;
        step();
        issue_valid          = 1'b0;
    endtask

    task automatic do_wb(input int p, input logic [4:0] id, input logic [63:0] d);
        wb_valid    = '0;
        wb_valid[p] = 1'b1;
        wb_tid[p]   = id;
        wb_res[p]   = d;
        step();
        wb_valid    = '0;
    endtask

    task automatic ack();
        commit_ack = 1'b1;
        step();
        commit_ack = 1'b0;
    endtask

    function automatic int clobber_count();
        int n = 0;
        for (int r = 0; r < 32; r++) begin
            if (rd_clobber[r] != NONE) n++;
        end
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        rs1 = 5'd1;
        #1;
        check("rst_ready", issue_ready, 1);
        check("rst_tid", issue_tid, 0);
        check("rst_cvalid", commit_valid, 0);
        check("rst_clobber", clobber_count(), 0);
        check("rst_fwd", rs1_fwd, 0);
        check("rst_data", rs1_data, 0);

        // Fill all 8 slots with rd=1..8
        for (int i = 0; i < 8; i++) begin
            check("fill_tid", issue_tid, 64'(i));
            do_issue(5'(i + 1), ALU, 1'b0);
        end
        check("full_ready", issue_ready, 0);
        check("full_clob3", rd_clobber[3], ALU);
        do_issue(5'd9, ALU, 1'b0);
        check("ninth_ready", issue_ready, 0);
        check("ninth_clob9", rd_clobber[9], NONE);
        check("ninth_tid", issue_tid, 0);

        // Out-of-order writeback, then head
        do_wb(0, 5'd3, 64'hDEAD);
        check("wb3_cvalid", commit_valid, 0);
        wb_valid  = 2'b10;
        wb_tid[1] = 5'd0;
        wb_res[1] = 64'h1;
        #1;
        check("wb0_same_cycle", commit_valid, 0);
        step();
        wb_valid = '0;
        check("wb0_cvalid", commit_valid, 1);
        check("wb0_head_tid", commit_instr.trans_id, 0);
        check("wb0_head_res", commit_instr.result, 64'h1);
        rs1 = 5'd4;
        #1;
        check("fwd_x4", rs1_fwd, 1);
        check("fwd_x4_data", rs1_data, 64'hDEAD);
        ack();
        check("ack_cvalid", commit_valid, 0);
        check("ack_head_tid", commit_instr.trans_id, 1);
        check("ack_ready", issue_ready, 1);
        check("ack_clob1", rd_clobber[1], NONE);

        // Wrap into slot 0, then full with simultaneous commit and issue
        check("wrap_tid", issue_tid, 0);
        do_issue(5'd10, ALU, 1'b0);
        check("refull_ready", issue_ready, 0);
        do_wb(1, 5'd1, 64'h11);
        check("head1_cvalid", commit_valid, 1);
        commit_ack           = 1'b1;
        issue_instr          = '0;
        issue_instr.rd       = 5'd11;
        issue_instr.fu       = ALU;
        issue_valid          = 1'b1;
        step();
        commit_ack           = 1'b0;
        issue_valid          = 1'b0;
        check("fullci_ready", issue_ready, 1);
        check("fullci_tid", issue_tid, 1);
        check("fullci_clob11", rd_clobber[11], NONE);
        check("fullci_head", commit_instr.trans_id, 2);
        check("fullci_cvalid", commit_valid, 0);
        do_issue(5'd11, ALU, 1'b0);
        check("reissue_ready", issue_ready, 0);
        check("reissue_clob11", rd_clobber[11], ALU);

        // Flush everything
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush1_ready", issue_ready, 1);
        check("flush1_tid", issue_tid, 0);
        check("flush1_cvalid", commit_valid, 0);
        check("flush1_clobber", clobber_count(), 0);

        // Two writers of x5: older ALU finished, younger LSU busy
        do_issue(5'd5, ALU, 1'b0);
        do_issue(5'd5, LSU, 1'b0);
        do_wb(0, 5'd0, 64'h10);
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        check("x5_clob", rd_clobber[5], LSU);
        check("x5_fwd_busy", rs1_fwd, 0);
        check("x5_cvalid", commit_valid, 1);
        check("x0_fwd", rs2_fwd, 0);
        check("x0_clob", rd_clobber[0], NONE);
        do_wb(1, 5'd1, 64'h20);
        check("x5_fwd", rs1_fwd, 1);
        check("x5_data", rs1_data, 64'h20);
        ack();
        check("x5_head_tid", commit_instr.trans_id, 1);
        check("x5_head_res", commit_instr.result, 64'h20);
        ack();
        check("x5_empty_cvalid", commit_valid, 0);
        check("x5_empty_clob", rd_clobber[5], NONE);

        // Excepting instruction finishes at issue
        check("ex_tid", issue_tid, 2);
        do_issue(5'd7, ALU, 1'b1);
        check("ex_cvalid", commit_valid, 1);
        check("ex_valid", commit_instr.ex.valid, 1);
        check("ex_head_tid", commit_instr.trans_id, 2);
        ack();
        check("ex_ack_cvalid", commit_valid, 0);
        do_wb(0, 5'd2, 64'h99);
        rs1 = 5'd7;
        #1;
        check("stale_cvalid", commit_valid, 0);
        check("stale_tid", issue_tid, 3);
        check("stale_ready", issue_ready, 1);
        check("stale_fwd", rs1_fwd, 0);
        check("stale_clob7", rd_clobber[7], NONE);

        // Flush with 5 busy and simultaneous wb/ack/issue
        for (int i = 1; i <= 5; i++) do_issue(5'(i), ALU, 1'b0);
        check("five_tid_wrap", issue_tid, 0);
        check("five_clobber", clobber_count(), 5);
        flush          = 1'b1;
        wb_valid       = 2'b01;
        wb_tid[0]      = 5'd3;
        wb_res[0]      = 64'h5;
        commit_ack     = 1'b1;
        issue_instr    = '0;
        issue_instr.rd = 5'd20;
        issue_instr.fu = ALU;
        issue_valid    = 1'b1;
        step();
        flush          = 1'b0;
        wb_valid       = '0;
        commit_ack     = 1'b0;
        issue_valid    = 1'b0;
        rs1            = 5'd1;
        #1;
        check("flush2_tid", issue_tid, 0);
        check("flush2_ready", issue_ready, 1);
        check("flush2_cvalid", commit_valid, 0);
        check("flush2_clobber", clobber_count(), 0);
        check("flush2_fwd", rs1_fwd, 0);
        do_wb(0, 5'd3, 64'h5);
        check("postflush_wb_cvalid", commit_valid, 0);
        check("postflush_wb_tid", issue_tid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
